// File: rtl/hack_mul_seq_if.sv
// Operand/result bundle between an operand source and the hack_mul_seq multiplier.
interface hack_mul_seq_if;
   logic        start;
   logic [15:0] a;
   logic [15:0] b;
   logic        busy;
   logic        done;
   logic [15:0] product;
   logic        zr;
   logic        ng;

   modport master (output start, a, b, input busy, done, product, zr, ng);
   modport slave  (input start, a, b, output busy, done, product, zr, ng);
endinterface

// File: rtl/hack_mul_seq.sv
// 16-bit shift-and-add multiplier; every addition runs through one Hack ALU fixed at x+y.
// Returns the low 16 bits of a*b after exactly 16 iterations, with ALU-style zr/ng flags.
module hack_mul_seq (
   input  logic           clock,
   input  logic           rst_n,
   hack_mul_seq_if.slave  bus
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t      state_q;
   logic [15:0] acc_q;
   logic [15:0] mcand_q;
   logic [15:0] mult_q;
   logic [4:0]  cnt_q;
   logic [15:0] product_q;
   logic        busy_q;
   logic        done_q;

   logic [15:0] alu_out;
   logic [15:0] acc_d;
   logic        unused_alu_zr;
   logic        unused_alu_ng;

   ALU u_alu (
      .x   (acc_q),
      .y   (mcand_q),
      .zx  (1'b0),
      .nx  (1'b0),
      .zy  (1'b0),
      .ny  (1'b0),
      .f   (1'b1),
      .no  (1'b0),
      .out (alu_out),
      .zr  (unused_alu_zr),
      .ng  (unused_alu_ng)
   );

   // Low product bits are sign-agnostic, so the plain unsigned shift-add is exact.
   assign acc_d = mult_q[0] ? alu_out : acc_q;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         acc_q     <= '0;
         mcand_q   <= '0;
         mult_q    <= '0;
         cnt_q     <= '0;
         product_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  acc_q   <= '0;
                  mcand_q <= bus.a;
                  mult_q  <= bus.b;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               acc_q   <= acc_d;
               mcand_q <= {mcand_q[14:0], 1'b0};
               mult_q  <= {1'b0, mult_q[15:1]};
               cnt_q   <= cnt_q + 5'd1;
               if (cnt_q == 5'd15) begin
                  product_q <= acc_d;
                  done_q    <= 1'b1;
                  state_q   <= S_DONE;
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.product = product_q;
   assign bus.zr      = (product_q == 16'd0);
   assign bus.ng      = product_q[15];
endmodule

// Combinational Hack ALU (zx/nx/zy/ny/f/no control set).
module ALU (
   input  logic [15:0] x,
   input  logic [15:0] y,
   input  logic        zx,
   input  logic        nx,
   input  logic        zy,
   input  logic        ny,
   input  logic        f,
   input  logic        no,
   output logic [15:0] out,
   output logic        zr,
   output logic        ng
);
   logic [15:0] x_z, x_n, y_z, y_n, f_out;

   assign x_z   = zx ? 16'd0 : x;
   assign x_n   = nx ? ~x_z : x_z;
   assign y_z   = zy ? 16'd0 : y;
   assign y_n   = ny ? ~y_z : y_z;
   assign f_out = f ? (x_n + y_n) : (x_n & y_n);
   assign out   = no ? ~f_out : f_out;
   assign zr    = (out == 16'd0);
   assign ng    = out[15];
endmodule

// File: tb/tb_hack_mul_seq.sv
// Bench for hack_mul_seq: directed cases plus random operands against a signed-product model.
module tb_hack_mul_seq;
   logic clock;
   logic rst_n;
   int   n_vec;
   int   n_miss;

   hack_mul_seq_if bus ();

   hack_mul_seq dut (
      .clock (clock),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: full two's-complement product, keep the low 16 bits.
   function automatic logic [15:0] model_mul(input logic [15:0] ma, input logic [15:0] mb);
      longint sp;
      sp = longint'($signed(ma)) * longint'($signed(mb));
      return sp[15:0];
   endfunction

   task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_v, input bit inject);
      int          cyc;
      int          busy_cyc;
      logic [15:0] exp_p;
      exp_p = model_mul(ta, tb_v);

      @(negedge clock);
      bus.start = 1'b1;
      bus.a     = ta;
      bus.b     = tb_v;
      @(negedge clock);
      bus.start = 1'b0;
      bus.a     = 16'($urandom);
      bus.b     = 16'($urandom);
      check_eq("busy_after_accept", 32'(bus.busy), 32'd1);
      busy_cyc = 1;
      cyc      = 0;
      while (!bus.done && cyc < 40) begin
         if (inject && cyc == 4) begin
            bus.start = 1'b1;
            bus.a     = 16'd7;
            bus.b     = 16'd7;
         end else begin
            bus.start = 1'b0;
         end
         @(negedge clock);
         cyc++;
         if (bus.busy) busy_cyc++;
      end
      check_eq("latency", 32'(cyc), 32'd16);
      check_eq("product", 32'(bus.product), 32'(exp_p));
      check_eq("zr", 32'(bus.zr), 32'(exp_p == 16'd0));
      check_eq("ng", 32'(bus.ng), 32'(exp_p[15]));
      if (inject) begin
         bus.start = 1'b1;
         bus.a     = 16'd7;
         bus.b     = 16'd7;
      end
      @(negedge clock);
      bus.start = 1'b0;
      check_eq("busy_cycles", 32'(busy_cyc), 32'd17);
      check_eq("busy_after_done", 32'(bus.busy), 32'd0);
      check_eq("done_one_cycle", 32'(bus.done), 32'd0);
      check_eq("product_held", 32'(bus.product), 32'(exp_p));
      $display("op a=%04h b=%04h inject=%0d -> product=%04h (model %04h) latency=%0d",
               ta, tb_v, inject, bus.product, exp_p, cyc);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_busy"},    32'(bus.busy),    32'd0);
      check_eq({tag, "_done"},    32'(bus.done),    32'd0);
      check_eq({tag, "_product"}, 32'(bus.product), 32'd0);
      check_eq({tag, "_zr"},      32'(bus.zr),      32'd1);
      check_eq({tag, "_ng"},      32'(bus.ng),      32'd0);
   endtask

   logic [15:0] dir_a [6];
   logic [15:0] dir_b [6];

   initial begin
      int done_seen;
      n_vec     = 0;
      n_miss    = 0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (3) @(negedge clock);
      check_reset_outputs("reset");
      rst_n = 1'b1;

      dir_a = '{16'd9, 16'hFFFD, 16'd300, 16'hFFFF, 16'd0,    16'h8000};
      dir_b = '{16'd15, 16'd7,   16'd300, 16'hFFFF, 16'd1234, 16'h8000};
      for (int i = 0; i < 6; i++) run_op(dir_a[i], dir_b[i], 1'b0);

      // Extra start pulses during RUN and DONE must not disturb the op.
      run_op(16'd5, 16'd6, 1'b1);

      // Reset in the middle of an op: everything clears, no done.
      @(negedge clock);
      bus.start = 1'b1;
      bus.a     = 16'd2;
      bus.b     = 16'd3;
      @(negedge clock);
      bus.start = 1'b0;
      repeat (7) @(negedge clock);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("midrun_reset");
      done_seen = 0;
      for (int i = 0; i < 24; i++) begin
         @(negedge clock);
         if (i == 2) rst_n = 1'b1;
         if (bus.done) done_seen++;
      end
      check_eq("no_done_after_reset", 32'(done_seen), 32'd0);
      check_eq("product_after_reset", 32'(bus.product), 32'd0);

      run_op(16'd4, 16'd4, 1'b0);

      for (int i = 0; i < 24; i++) begin
         run_op(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
